// File: rtl/patch_streamer.sv
// Purpose : serialise the patchifier's all_patches array channel by channel onto a valid/ready stream.
// Latency : first beat valid two edges after patch_state is first sampled DONE, then one beat per cycle.
// Backpressure: single registered output stage, m_* held stable while m_valid && !m_ready.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   patch_state       patchifier state (00 IDLE, 01 PROCESSING, 10 DONE)
//   all_patches       patchifier frame, read in place (no local copy)
//   output_taken      one-cycle release pulse back to the patchifier
//   m_valid/m_ready   stream handshake
//   m_data            one channel of one pixel
//   m_patch_idx       patch index of the beat
//   m_elem_idx        pos*NUM_CHANNELS+ch within the patch
//   m_sop/m_eop       first/last beat of a patch
//   m_last            last beat of the frame
//   busy              FSM not in IDLE
//   abort_err         sticky: patch_state left DONE mid-stream
//   frame_count       completed frames, wraps at 2^16
module patch_streamer #(
    parameter int CHANNEL_SIZE      = 8,
    parameter int NUM_CHANNELS      = 3,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE*NUM_CHANNELS,
    parameter int TOTAL_NUM_PATCHES = 16,
    parameter int PATCH_VECTOR_SIZE = 256,
    parameter int ELEMS_PER_PATCH   = PATCH_VECTOR_SIZE*NUM_CHANNELS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [1:0]                            patch_state,
    input  logic [TOTAL_NUM_PATCHES-1:0][PATCH_VECTOR_SIZE-1:0][PIXEL_WIDTH-1:0] all_patches,
    output logic                                  output_taken,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [CHANNEL_SIZE-1:0]               m_data,
    output logic [$clog2(TOTAL_NUM_PATCHES)-1:0]  m_patch_idx,
    output logic [$clog2(ELEMS_PER_PATCH)-1:0]    m_elem_idx,
    output logic                                  m_sop,
    output logic                                  m_eop,
    output logic                                  m_last,
    output logic                                  busy,
    output logic                                  abort_err,
    output logic [15:0]                           frame_count
);

    localparam int PATCH_W = $clog2(TOTAL_NUM_PATCHES);
    localparam int POS_W   = $clog2(PATCH_VECTOR_SIZE);
    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ELEM_W  = $clog2(ELEMS_PER_PATCH);

    localparam logic [PATCH_W-1:0] LAST_PATCH = PATCH_W'(TOTAL_NUM_PATCHES-1);
    localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(PATCH_VECTOR_SIZE-1);
    localparam logic [CH_W-1:0]    LAST_CH    = CH_W'(NUM_CHANNELS-1);
    localparam logic [ELEM_W-1:0]  LAST_ELEM  = ELEM_W'(ELEMS_PER_PATCH-1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_STREAM  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               r_state;

    // Read counters point at the beat that the next load will present.
    logic [PATCH_W-1:0]   r_patch;
    logic [POS_W-1:0]     r_pos;
    logic [CH_W-1:0]      r_ch;
    logic [ELEM_W-1:0]    r_elem;

    logic                 w_done;
    logic                 w_active;
    logic                 w_abort;
    logic                 w_load;
    logic                 w_elem_last;
    logic [PIXEL_WIDTH-1:0]  w_pixel;
    logic [CHANNEL_SIZE-1:0] w_chan;

    assign w_done      = (patch_state == 2'b10);
    assign w_active    = (r_state == S_SETTLE) || (r_state == S_STREAM);
    assign w_abort     = w_active && !w_done;
    // In STREAM the output register is always full, so a free slot is simply m_ready.
    // The m_last beat is not followed by a load: accepting it ends the frame.
    assign w_load      = w_done && ((r_state == S_SETTLE) ||
                                    ((r_state == S_STREAM) && m_ready && !m_last));
    assign w_elem_last = (r_elem == LAST_ELEM);
    assign w_pixel     = all_patches[r_patch][r_pos];
    assign busy        = (r_state != S_IDLE);

    // Channel 0 sits in the pixel LSBs.
    always_comb begin
        w_chan = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_chan = w_pixel[c*CHANNEL_SIZE +: CHANNEL_SIZE];
            end
        end
    end

    // Control FSM: state, handshake valid, release pulse and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            m_valid      <= 1'b0;
            output_taken <= 1'b0;
            abort_err    <= 1'b0;
            frame_count  <= '0;
        end else begin
            output_taken <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_done) begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE, S_STREAM: begin
                    if (!w_done) begin
                        m_valid   <= 1'b0;
                        abort_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_state == S_SETTLE) begin
                        m_valid <= 1'b1;
                        r_state <= S_STREAM;
                    end else if (m_ready && m_last) begin
                        m_valid      <= 1'b0;
                        output_taken <= 1'b1;
                        frame_count  <= frame_count + 16'd1;
                        r_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: output register and read counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_patch     <= '0;
            r_pos       <= '0;
            r_ch        <= '0;
            r_elem      <= '0;
            m_data      <= '0;
            m_patch_idx <= '0;
            m_elem_idx  <= '0;
            m_sop       <= 1'b0;
            m_eop       <= 1'b0;
            m_last      <= 1'b0;
        end else if (w_abort) begin
            // Next DONE must restart from beat 0.
            r_patch <= '0;
            r_pos   <= '0;
            r_ch    <= '0;
            r_elem  <= '0;
        end else if (w_load) begin
            m_data      <= w_chan;
            m_patch_idx <= r_patch;
            m_elem_idx  <= r_elem;
            m_sop       <= (r_elem == '0);
            m_eop       <= w_elem_last;
            m_last      <= w_elem_last && (r_patch == LAST_PATCH);

            r_elem <= w_elem_last ? '0 : r_elem + ELEM_W'(1);
            if (r_ch == LAST_CH) begin
                r_ch <= '0;
                if (r_pos == LAST_POS) begin
                    r_pos   <= '0;
                    r_patch <= (r_patch == LAST_PATCH) ? '0 : r_patch + PATCH_W'(1);
                end else begin
                    r_pos <= r_pos + POS_W'(1);
                end
            end else begin
                r_ch <= r_ch + CH_W'(1);
            end
        end
    end

endmodule
